// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor: op encodings, flag order.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipelined_cla_addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBB = 2'b11
  } op_e;

  // Flag vector bit positions, packed as {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Carry injected into the lowest segment. SUB forces 1 to complete the
  // two's complement of b; SBB treats cin = 1 as "no borrow".
  function automatic logic carry_in(input op_e op, input logic cin);
    case (op)
      OP_ADD:  return 1'b0;
      OP_SUB:  return 1'b1;
      default: return cin;
    endcase
  endfunction

endpackage

// File: rtl/pipelined_cla_addsub_cla_segment.sv
// Combinational SEG_W-bit two-level carry-lookahead adder built from 4-bit groups.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline decides when results are captured.
// Ports: a, b, cin -> sum, cout, px (segment propagate), gx (segment generate).
module cla_segment #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             px,
  output logic             gx
);

  localparam int NG = SEG_W / 4;

  logic [SEG_W-1:0] p;
  logic [SEG_W-1:0] g;
  logic [SEG_W-1:0] c;
  logic [NG-1:0]    grp_p;
  logic [NG-1:0]    grp_g;
  logic [NG:0]      grp_c;

  assign p = a ^ b;
  assign g = a & b;

  // First level: propagate/generate of each 4-bit group.
  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int j = 0; j < NG; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
  end

  // Second level: every group carry and every bit carry is written as a flat
  // sum of products of generates and propagates, so no carry depends on a
  // neighbouring carry.
  always_comb begin
    logic acc;
    logic term;
    acc   = 1'b0;
    term  = 1'b0;
    grp_c = '0;
    c     = '0;
    grp_c[0] = cin;
    for (int j = 1; j <= NG; j++) begin
      acc = cin;
      for (int m = 0; m < j; m++) acc = acc & grp_p[m];
      for (int i = 0; i < j; i++) begin
        term = grp_g[i];
        for (int m = i + 1; m < j; m++) term = term & grp_p[m];
        acc = acc | term;
      end
      grp_c[j] = acc;
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        acc = grp_c[j];
        for (int m = 0; m < i; m++) acc = acc & p[4*j+m];
        for (int k = 0; k < i; k++) begin
          term = g[4*j+k];
          for (int m = k + 1; m < i; m++) term = term & p[4*j+m];
          acc = acc | term;
        end
        c[4*j+i] = acc;
      end
    end
  end

  // Segment-level generate: carry out of the segment assuming cin = 0.
  always_comb begin
    logic term;
    term = 1'b0;
    gx   = 1'b0;
    for (int i = 0; i < NG; i++) begin
      term = grp_g[i];
      for (int m = i + 1; m < NG; m++) term = term & grp_p[m];
      gx = gx | term;
    end
  end

  assign px   = &grp_p;
  assign cout = grp_c[NG];
  assign sum  = p ^ c;

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined ADD/SUB/ADC/SBB with NZCV flags, one CLA segment per stage; only the inter-segment carry crosses stages.
// Latency: NSEG = WIDTH/SEG_W cycles from accepted input to out_valid; one result per cycle.
// Backpressure: single global enable adv = ~out_valid | out_ready; when low every stage holds and in_ready = 0.
// Ports: clk, rst_n; in_valid/in_ready with a, b, op, cin; out_valid/out_ready with sum, flag_n/z/c/v.
module pipelined_cla_addsub
  import pipelined_cla_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int NSEG = WIDTH / SEG_W;
  // Number of inter-stage register sets; kept at least 1 so arrays stay legal when NSEG = 1.
  localparam int PD   = (NSEG > 1) ? NSEG - 1 : 1;
  localparam int LAST = NSEG - 1;

  if ((WIDTH % SEG_W) != 0 || (SEG_W % 4) != 0 || WIDTH < 16 || WIDTH > 64) begin : g_bad_cfg
    $error("pipelined_cla_addsub: WIDTH must be a multiple of SEG_W in 16..64 and SEG_W a multiple of 4");
  end

  logic adv;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  logic [WIDTH-1:0] bx;
  logic             c0;
  assign bx = op[0] ? ~b : b;
  assign c0 = carry_in(op_e'(op), cin);

  // Stage inputs (combinational view of what stage k works on this cycle).
  logic [WIDTH-1:0] st_a   [NSEG];
  logic [WIDTH-1:0] st_bx  [NSEG];
  logic [WIDTH-1:0] st_s   [NSEG];
  logic [WIDTH-1:0] nxt_s  [NSEG];
  logic             st_c   [NSEG];
  logic             st_v   [NSEG];
  logic             nxt_c  [NSEG];
  logic             seg_co [NSEG];
  logic             seg_px [NSEG];
  logic             seg_gx [NSEG];
  logic [SEG_W-1:0] seg_sum[NSEG];

  // Inter-stage registers: full-width operands and partial result travel as skew registers.
  logic [WIDTH-1:0] a_q  [PD];
  logic [WIDTH-1:0] bx_q [PD];
  logic [WIDTH-1:0] s_q  [PD];
  logic             c_q  [PD];
  logic             vld_q[PD];

  logic             ov_q;
  logic [WIDTH-1:0] sum_q;
  logic [3:0]       flag_q;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign st_a[k]  = a;
      assign st_bx[k] = bx;
      assign st_s[k]  = '0;
      assign st_c[k]  = c0;
      assign st_v[k]  = in_valid & adv;
    end else begin : g_next
      assign st_a[k]  = a_q[k-1];
      assign st_bx[k] = bx_q[k-1];
      assign st_s[k]  = s_q[k-1];
      assign st_c[k]  = c_q[k-1];
      assign st_v[k]  = vld_q[k-1];
    end

    cla_segment #(.SEG_W(SEG_W)) u_seg (
      .a    (st_a[k][k*SEG_W +: SEG_W]),
      .b    (st_bx[k][k*SEG_W +: SEG_W]),
      .cin  (st_c[k]),
      .sum  (seg_sum[k]),
      .cout (seg_co[k]),
      .px   (seg_px[k]),
      .gx   (seg_gx[k])
    );

    // Carry handed to the next stage, formed from segment P/G (equal to cout).
    assign nxt_c[k] = seg_gx[k] | (seg_px[k] & st_c[k]);
    // Bits above the current segment are always zero, so OR merges the new slice.
    assign nxt_s[k] = st_s[k] | (WIDTH'(seg_sum[k]) << (k * SEG_W));
  end

  logic [WIDTH-1:0] res;
  logic [3:0]       flag_d;
  assign res = nxt_s[LAST];
  always_comb begin
    flag_d         = '0;
    flag_d[FLAG_N] = res[WIDTH-1];
    flag_d[FLAG_Z] = ~|res;
    flag_d[FLAG_C] = seg_co[LAST];
    flag_d[FLAG_V] = (st_a[LAST][WIDTH-1] == st_bx[LAST][WIDTH-1]) &
                     (res[WIDTH-1] != st_a[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PD; k++) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        s_q[k]   <= '0;
      end
      ov_q   <= 1'b0;
      sum_q  <= '0;
      flag_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < NSEG - 1; k++) begin
        vld_q[k] <= st_v[k];
        c_q[k]   <= nxt_c[k];
        a_q[k]   <= st_a[k];
        bx_q[k]  <= st_bx[k];
        s_q[k]   <= nxt_s[k];
      end
      ov_q <= st_v[LAST];
      // Bubbles leave the visible result untouched.
      if (st_v[LAST]) begin
        sum_q  <= res;
        flag_q <= flag_d;
      end
    end
  end

  assign out_valid = ov_q;
  assign sum       = sum_q;
  assign flag_n    = flag_q[FLAG_N];
  assign flag_z    = flag_q[FLAG_Z];
  assign flag_c    = flag_q[FLAG_C];
  assign flag_v    = flag_q[FLAG_V];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  // 32-bit instance (latency 2)
  logic        in_valid, in_ready, out_valid, out_ready, cin;
  logic [31:0] a, b, sum;
  logic [1:0]  op;
  logic        flag_n, flag_z, flag_c, flag_v;
  // 64-bit instance (latency 4)
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_cin;
  logic [63:0] w_a, w_b, w_sum;
  logic [1:0]  w_op;
  logic        w_flag_n, w_flag_z, w_flag_c, w_flag_v;

  int checks = 0;
  int errors = 0;

  pipelined_cla_addsub #(.WIDTH(32), .SEG_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  pipelined_cla_addsub #(.WIDTH(64), .SEG_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .a(w_a), .b(w_b), .op(w_op), .cin(w_cin), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .sum(w_sum), .flag_n(w_flag_n), .flag_z(w_flag_z), .flag_c(w_flag_c), .flag_v(w_flag_v)
  );

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic, result packed as {N,Z,C,V,sum}.
  function automatic logic [35:0] model32(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic [1:0] mop, input logic mcin);
    logic [31:0] bxm;
    logic        c0m;
    logic [32:0] full;
    logic [31:0] s;
    bxm  = mop[0] ? ~mb : mb;
    c0m  = (mop == 2'b00) ? 1'b0 : (mop == 2'b01) ? 1'b1 : mcin;
    full = {1'b0, ma} + {1'b0, bxm} + {32'd0, c0m};
    s    = full[31:0];
    return {s[31], (s == 32'd0), full[32], (ma[31] == bxm[31]) && (s[31] != ma[31]), s};
  endfunction

  task automatic single32(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic [1:0] top, input logic tcin,
                          input logic [31:0] esum, input logic [3:0] eflags);
    @(negedge clk);
    a = ta; b = tb; op = top; cin = tcin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; op = ~top; cin = ~tcin; a = 32'hDEAD_BEEF;
    check({tag, "_lat1_vld"}, 68'(out_valid), 68'(0));
    @(negedge clk);
    check({tag, "_vld"}, 68'(out_valid), 68'(1));
    check({tag, "_res"}, 68'({flag_n, flag_z, flag_c, flag_v, sum}), 68'({eflags, esum}));
  endtask

  task automatic single64(input string tag, input logic [63:0] ta, input logic [63:0] tb,
                          input logic [1:0] top, input logic tcin,
                          input logic [63:0] esum, input logic [3:0] eflags);
    @(negedge clk);
    w_a = ta; w_b = tb; w_op = top; w_cin = tcin; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0; w_op = ~top; w_cin = ~tcin;
    check({tag, "_lat1_vld"}, 68'(w_out_valid), 68'(0));
    for (int i = 2; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_latn_vld"}, 68'(w_out_valid), 68'(0));
    end
    @(negedge clk);
    check({tag, "_vld"}, 68'(w_out_valid), 68'(1));
    check({tag, "_res"}, {w_flag_n, w_flag_z, w_flag_c, w_flag_v, w_sum}, {eflags, esum});
  endtask

  // Streams n random ops; out_ready drops for stall_len cycles from cycle stall_at.
  task automatic run_stream(input string tag, input int n, input int stall_at, input int stall_len);
    logic [35:0] expq[$];
    logic [35:0] e, hv;
    logic [31:0] ca, cb;
    logic [1:0]  cop;
    logic        ccin, acc, held;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1; acc = 1'b0; held = 1'b0; hv = '0;
    ca = $urandom; cb = $urandom; cop = 2'($urandom_range(0, 3)); ccin = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < n + stall_len + 20 && got < n; cyc++) begin
      @(negedge clk);
      if (acc) begin
        sent++;
        ca = $urandom; cb = $urandom; cop = 2'($urandom_range(0, 3)); ccin = 1'($urandom_range(0, 1));
      end
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      if (out_valid) begin
        if (held) check({tag, "_hold"}, 68'({flag_n, flag_z, flag_c, flag_v, sum}), 68'(hv));
        if (out_ready) begin
          if (expq.size() == 0) check({tag, "_extra"}, 68'(expq.size()), 68'(1));
          else begin
            e = expq.pop_front();
            check({tag, "_res"}, 68'({flag_n, flag_z, flag_c, flag_v, sum}), 68'(e));
          end
          got++;
          if (first < 0) first = cyc;
          last = cyc;
          held = 1'b0;
        end else begin
          hv   = {flag_n, flag_z, flag_c, flag_v, sum};
          held = 1'b1;
        end
      end
      in_valid = (sent < n);
      a = ca; b = cb; op = cop; cin = ccin;
      #1;
      if (out_valid && !out_ready) check({tag, "_inrdy"}, 68'(in_ready), 68'(0));
      acc = in_valid && in_ready;
      if (acc) expq.push_back(model32(ca, cb, cop, ccin));
    end
    check({tag, "_count"}, 68'(got), 68'(n));
    check({tag, "_leftover"}, 68'(expq.size()), 68'(0));
    if (stall_len == 0) check({tag, "_consecutive"}, 68'(last - first), 68'(n - 1));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0; cin = 1'b0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0; w_op = '0; w_cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vld", 68'(out_valid), 68'(0));
    check("rst_sum", 68'({flag_n, flag_z, flag_c, flag_v, sum}), 68'(0));
    check("rst_inrdy", 68'(in_ready), 68'(1));
    check("rst64_out", {w_flag_n, w_flag_z, w_flag_c, w_flag_v, w_sum}, 68'(0));
    rst_n = 1'b1;

    // Directed 32-bit vectors: flags {N,Z,C,V}
    single32("add_segcarry", 32'h0000_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h0001_0000, 4'b0000);
    single32("sub_ovf",      32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 32'h7FFF_FFFF, 4'b0011);
    single32("sub_neg",      32'h0000_0005, 32'h0000_0007, 2'b01, 1'b0, 32'hFFFF_FFFE, 4'b1000);
    single32("adc_wrap",     32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b1, 32'h0000_0000, 4'b0110);
    single32("sbb_borrow",   32'h0000_0010, 32'h0000_0001, 2'b11, 1'b0, 32'h0000_000E, 4'b0010);
    single32("add_wrap",     32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 1'b1, 32'h0000_0000, 4'b0110);
    single32("add_posovf",   32'h7FFF_FFFF, 32'h0000_0001, 2'b00, 1'b0, 32'h8000_0000, 4'b1001);
    single32("sbb_noborrow", 32'h0000_0010, 32'h0000_0001, 2'b11, 1'b1, 32'h0000_000F, 4'b0010);

    // Full-throughput stream and stall in flight
    run_stream("stream", 8, 1000, 0);
    run_stream("stall", 6, 3, 3);

    // Reset with two ops in flight
    @(negedge clk);
    a = 32'd1; b = 32'd2; op = 2'b00; in_valid = 1'b1;
    @(negedge clk);
    a = 32'd3; b = 32'd4;
    @(negedge clk);
    in_valid = 1'b0;
    check("rstmid_pre_vld", 68'(out_valid), 68'(1));
    check("rstmid_pre_sum", 68'(sum), 68'(3));
    rst_n = 1'b0;
    #1;
    check("rstmid_vld", 68'(out_valid), 68'(0));
    check("rstmid_out", 68'({flag_n, flag_z, flag_c, flag_v, sum}), 68'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstmid_quiet", 68'(out_valid), 68'(0));
    end

    // Directed 64-bit vectors
    single64("w_add_cross", 64'h0000_0000_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 64'h0000_0001_0000_0000, 4'b0000);
    single64("w_add_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 64'h0, 4'b0110);
    single64("w_sub_ovf",   64'h8000_0000_0000_0000, 64'h1, 2'b01, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    single64("w_adc_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b10, 1'b1, 64'h0, 4'b0110);
    single64("w_sbb",       64'h10, 64'h1, 2'b11, 1'b0, 64'hE, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
